// File: rtl/tt_um_carry_select_sub8.sv
// 8-bit subtractor A-B built from two 4-bit carry-select nibbles, sequenced by
// a three-state FSM (IDLE -> LOW -> HIGH) with registered result and flags.
module tt_um_carry_select_sub8 (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [3:0] lo_q;
  logic       c4_q;
  logic [4:0] hi0_q;   // upper candidate assuming no carry in, with its carry
  logic [4:0] hi1_q;   // upper candidate assuming carry in, with its carry
  logic [7:0] result_q;
  logic       ovf_q;
  logic       busy_q;
  logic       done_q;
  logic       borrow_q;
  logic       zero_q;

  logic load_a;
  logic load_b;
  logic start;
  assign load_a = uio_in[0];
  assign load_b = uio_in[1];
  assign start  = uio_in[2];

  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, uio_in[7:3]};

  // Subtraction as A + ~B + 1: the +1 is the carry into the low nibble.
  logic [4:0] lo_sum;
  logic [4:0] hi_sum0;
  logic [4:0] hi_sum1;
  logic [4:0] hi_sel;
  logic [7:0] diff;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    lo_sum  = 5'd0;
    hi_sum0 = 5'd0;
    hi_sum1 = 5'd0;
    hi_sel  = 5'd0;
    lo_sum  = {1'b0, a_q[3:0]} + {1'b0, ~b_q[3:0]} + 5'd1;
    hi_sum0 = {1'b0, a_q[7:4]} + {1'b0, ~b_q[7:4]};
    hi_sum1 = {1'b0, a_q[7:4]} + {1'b0, ~b_q[7:4]} + 5'd1;
    hi_sel  = c4_q ? hi1_q : hi0_q;
  end

  assign diff = {hi_sel[3:0], lo_q};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      lo_q     <= 4'h0;
      c4_q     <= 1'b0;
      hi0_q    <= 5'd0;
      hi1_q    <= 5'd0;
      result_q <= 8'h00;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_a) a_q <= ui_in;
          if (load_b) b_q <= ui_in;
          if (load_a || load_b || start) done_q <= 1'b0;
          // Operands loaded on this same edge are seen by LOW next cycle.
          if (start) begin
            state  <= LOW;
            busy_q <= 1'b1;
          end
        end
        LOW: begin
          lo_q  <= lo_sum[3:0];
          c4_q  <= lo_sum[4];
          hi0_q <= hi_sum0;
          hi1_q <= hi_sum1;
          state <= HIGH;
        end
        HIGH: begin
          result_q <= diff;
          borrow_q <= ~hi_sel[4];
          zero_q   <= (diff == 8'h00);
          ovf_q    <= (a_q[7] != b_q[7]) && (diff[7] != a_q[7]);
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign uo_out  = result_q;
  assign uio_out = {zero_q, borrow_q, done_q, busy_q, ovf_q, 3'b000};
  assign uio_oe  = 8'hF8;

endmodule

// File: tb/tb_tt_um_carry_select_sub8.sv
// Self-checking bench: a behavioural model pushes expected results into a
// scoreboard at start, and a monitor pops them when done rises.
module tb_tt_um_carry_select_sub8;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_carry_select_sub8 dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    logic       borrow;
    logic       zero;
    int         start_cyc;
  } exp_t;

  exp_t sb[$];

  // Reference model: plain A-B arithmetic plus the FSM timing.
  int         cyc = 0;
  int         m_state = 0;
  logic [7:0] m_a = 8'h00;
  logic [7:0] m_b = 8'h00;
  logic [7:0] m_res = 8'h00;
  logic       m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0;
      m_a     = 8'h00;
      m_b     = 8'h00;
      m_res   = 8'h00;
      m_done  = 1'b0;
      sb.delete();
    end else begin
      cyc++;
      case (m_state)
        0: begin
          if (uio_in[0]) m_a = ui_in;
          if (uio_in[1]) m_b = ui_in;
          if (uio_in[0] || uio_in[1] || uio_in[2]) m_done = 1'b0;
          if (uio_in[2]) begin
            exp_t e;
            logic [7:0] d;
            d           = m_a - m_b;
            e.res       = d;
            e.borrow    = (m_a < m_b);
            e.zero      = (d == 8'h00);
            e.ovf       = (m_a[7] != m_b[7]) && (d[7] != m_a[7]);
            e.start_cyc = cyc;
            sb.push_back(e);
            m_state = 1;
          end
        end
        1: m_state = 2;
        default: begin
          m_res   = m_a - m_b;
          m_done  = 1'b1;
          m_state = 0;
        end
      endcase
    end
  end

  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", uio_out[4], (m_state != 0));
      check("done", uio_out[5], m_done);
      check("uo_out_hold", uo_out, m_res);
      if (uio_out[5] && !prev_done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("res", uo_out, e.res);
          check("ovf", uio_out[3], e.ovf);
          check("borrow", uio_out[6], e.borrow);
          check("zero", uio_out[7], e.zero);
          check("latency", cyc - e.start_cyc, 2);
        end
      end
    end
    prev_done = uio_out[5];
  end

  task automatic drive(input logic [7:0] d, input logic la, input logic lb, input logic st);
    @(negedge clk);
    ui_in  = d;
    uio_in = {5'b0, st, lb, la};
  endtask

  // Four cycles per operation: load A, load B + start, then LOW and HIGH.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b);
    drive(a, 1'b1, 1'b0, 1'b0);
    drive(b, 1'b0, 1'b1, 1'b1);
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  logic [7:0] corners [12] = '{8'h00, 8'h01, 8'h0F, 8'h10, 8'h55, 8'h7E,
                               8'h7F, 8'h80, 8'h81, 8'hAA, 8'hF0, 8'hFF};

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #12;
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'hF8);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h5A, 8'h3C);
    @(negedge clk);
    check("d027_res", uo_out, 8'h1E);
    check("d027_flags", uio_out, 8'b0010_0000);

    do_op(8'h3C, 8'h5A);
    @(negedge clk);
    check("d028_res", uo_out, 8'hE2);
    check("d028_flags", uio_out, 8'b0110_0000);

    do_op(8'h80, 8'h01);
    @(negedge clk);
    check("d029a_res", uo_out, 8'h7F);
    check("d029a_flags", uio_out, 8'b0010_1000);

    do_op(8'h77, 8'h77);
    @(negedge clk);
    check("d029b_res", uo_out, 8'h00);
    check("d029b_flags", uio_out, 8'b1010_0000);

    // Same-cycle dual load feeds both operands from ui_in.
    drive(8'hC3, 1'b1, 1'b1, 1'b1);
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("dual_load_res", uo_out, 8'h00);

    // Load and start during LOW must be ignored.
    drive(8'h10, 1'b1, 1'b0, 1'b0);
    drive(8'h01, 1'b0, 1'b1, 1'b1);
    drive(8'hFF, 1'b1, 1'b0, 1'b1);
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("d030_res", uo_out, 8'h0F);
    drive(8'h00, 1'b0, 1'b1, 1'b1);
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("d030_a_kept", uo_out, 8'h10);

    // Continuous start relaunches one operation every three cycles.
    drive(8'h09, 1'b1, 1'b0, 1'b0);
    drive(8'h03, 1'b0, 1'b1, 1'b1);
    repeat (8) drive(8'h00, 1'b0, 1'b0, 1'b1);
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    // Reset in HIGH clears every output immediately and kills the result.
    drive(8'hA5, 1'b1, 1'b0, 1'b0);
    drive(8'h11, 1'b0, 1'b1, 1'b1);
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("d031_uo_out", uo_out, 8'h00);
    check("d031_uio_out", uio_out, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("d031_done_low", uio_out[5], 1'b0);

    foreach (corners[i]) begin
      foreach (corners[j]) do_op(corners[i], corners[j]);
    end
    for (int n = 0; n < 2500; n++) begin
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    repeat (10) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
